// File: rtl/race_gte_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : race_pkg
// Brief   : Shared types and helpers for the race-logic GTE cell sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package race_pkg;

    localparam int T_W_DEFAULT = 4;

    // All-ones value of a w-bit spike time, used as the "no spike" marker.
    function automatic logic [31:0] inf(input int w);
        inf = (32'd1 << w) - 32'd1;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/race_gte_sched_edge_gen.sv
`default_nettype none
// ============================================================================
// Module  : race_edge_gen
// Brief   : Converts a spike time into a monotone rising step inside RUN.
// Revision: 1.0 - initial release
// ============================================================================
module race_edge_gen
    import race_pkg::*;
#(
    parameter int T_W   = T_W_DEFAULT,
    parameter int CNT_W = 4
) (
    input  logic             run,
    input  logic [CNT_W-1:0] t,
    input  logic [T_W-1:0]   t_spike,
    output logic             step
);

    localparam logic [31:0]    c_inf32 = inf(T_W);
    localparam logic [T_W-1:0] c_inf   = c_inf32[T_W-1:0];

    assign step = run && (t_spike != c_inf) && (32'(t) >= 32'(t_spike));

endmodule
`default_nettype wire

// File: rtl/race_gte_sched.sv
`default_nettype none
// ============================================================================
// Module  : race_gte_sched
// Brief   : Request/response sequencer that resets, drives and timestamps one
//           temporal greater-than-or-equal cell.
// Revision: 1.0 - initial release
// ============================================================================
module race_gte_sched
    import race_pkg::*;
#(
    parameter int T_W        = T_W_DEFAULT,
    parameter int GAMMA      = 16,
    parameter int RST_CYCLES = 2
) (
    input  logic           aclk,
    input  logic           grst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [T_W-1:0] req_ta,
    input  logic [T_W-1:0] req_tb,
    output logic           cell_rst,
    output logic           cell_a,
    output logic           cell_b,
    input  logic           cell_q,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_fired,
    output logic [T_W-1:0] rsp_tq,
    output logic           rsp_err,
    output logic           busy
);

    localparam int CNT_W  = (GAMMA > 1) ? $clog2(GAMMA) : 1;
    localparam int RCNT_W = $clog2(RST_CYCLES + 1);

    localparam logic [31:0]       c_inf32  = inf(T_W);
    localparam logic [T_W-1:0]    c_inf    = c_inf32[T_W-1:0];
    localparam logic [CNT_W-1:0]  c_t_last = CNT_W'(GAMMA - 1);
    localparam logic [RCNT_W-1:0] c_r_last = RCNT_W'(RST_CYCLES - 1);

    state_t            r_state;
    logic              r_armed;
    logic [CNT_W-1:0]  r_t;
    logic [RCNT_W-1:0] r_rcnt;
    logic [T_W-1:0]    r_ta;
    logic [T_W-1:0]    r_tb;
    logic [T_W-1:0]    r_tq;
    logic              r_fired;
    logic              r_err;

    logic w_run;
    logic w_a;
    logic w_b;

    assign w_run = (r_state == RUN);

    race_edge_gen #(
        .T_W   (T_W),
        .CNT_W (CNT_W)
    ) u_edge_a (
        .run     (w_run),
        .t       (r_t),
        .t_spike (r_ta),
        .step    (w_a)
    );

    race_edge_gen #(
        .T_W   (T_W),
        .CNT_W (CNT_W)
    ) u_edge_b (
        .run     (w_run),
        .t       (r_t),
        .t_spike (r_tb),
        .step    (w_b)
    );

    always_ff @(posedge aclk or negedge grst) begin
        if (!grst) begin
            r_state <= IDLE;
            r_armed <= 1'b0;
            r_t     <= '0;
            r_rcnt  <= '0;
            r_ta    <= c_inf;
            r_tb    <= c_inf;
            r_tq    <= c_inf;
            r_fired <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            // Holds off acceptance until the first edge after reset release.
            r_armed <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (req_valid && r_armed) begin
                        r_ta    <= req_ta;
                        r_tb    <= req_tb;
                        r_tq    <= c_inf;
                        r_fired <= 1'b0;
                        r_err   <= 1'b0;
                        r_rcnt  <= '0;
                        r_t     <= '0;
                        r_state <= RESET;
                    end
                end
                RESET: begin
                    if (r_rcnt == c_r_last) begin
                        r_rcnt  <= '0;
                        r_t     <= '0;
                        r_state <= RUN;
                    end else begin
                        r_rcnt <= r_rcnt + RCNT_W'(1);
                    end
                end
                RUN: begin
                    if (cell_q && !r_fired) begin
                        r_fired <= 1'b1;
                        r_tq    <= r_t[T_W-1:0];
                    end
                    if (cell_q && !w_a) begin
                        r_err <= 1'b1;
                    end
                    // Full window always elapses; an early q does not end RUN.
                    if (r_t == c_t_last) begin
                        r_t     <= '0;
                        r_state <= DONE;
                    end else begin
                        r_t <= r_t + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = r_armed && (r_state == IDLE);
    assign cell_rst  = !w_run;
    assign cell_a    = w_a;
    assign cell_b    = w_b;
    assign rsp_valid = (r_state == DONE);
    assign rsp_fired = r_fired;
    assign rsp_tq    = r_tq;
    assign rsp_err   = r_err;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_race_gte_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_race_gte_sched
// Brief   : Self-checking bench for race_gte_sched with a behavioural GTE cell.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_race_gte_sched;

    localparam int T_W        = 4;
    localparam int GAMMA      = 16;
    localparam int RST_CYCLES = 2;
    localparam int c_inf      = (1 << T_W) - 1;

    logic           aclk      = 1'b0;
    logic           grst      = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [T_W-1:0] req_ta    = '0;
    logic [T_W-1:0] req_tb    = '0;
    logic           cell_rst;
    logic           cell_a;
    logic           cell_b;
    logic           cell_q;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic           rsp_fired;
    logic [T_W-1:0] rsp_tq;
    logic           rsp_err;
    logic           busy;

    int checks   = 0;
    int failures = 0;

    int   cell_mode = 0;
    int   fault_t   = 0;
    int   r_envt;
    logic r_inhibit;

    always #5 aclk = ~aclk;

    race_gte_sched #(
        .T_W        (T_W),
        .GAMMA      (GAMMA),
        .RST_CYCLES (RST_CYCLES)
    ) dut (
        .aclk      (aclk),
        .grst      (grst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ta    (req_ta),
        .req_tb    (req_tb),
        .cell_rst  (cell_rst),
        .cell_a    (cell_a),
        .cell_b    (cell_b),
        .cell_q    (cell_q),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_fired (rsp_fired),
        .rsp_tq    (rsp_tq),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    // GTE cell: passes a only if b arrived no later; a arriving first inhibits.
    always_ff @(posedge aclk) begin
        if (cell_rst) begin
            r_envt    <= 0;
            r_inhibit <= 1'b0;
        end else begin
            r_envt <= r_envt + 1;
            if (cell_a && !cell_b) r_inhibit <= 1'b1;
        end
    end

    always_comb begin
        cell_q = 1'b0;
        if (cell_mode == 1) cell_q = !cell_rst && (r_envt >= fault_t);
        else                cell_q = cell_a && cell_b && !r_inhibit;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input int ta, input int tb, input int mode, input int ft,
                                  output int fired, output int tq, output int err);
        if (mode == 1) begin
            fired = 1;
            tq    = ft;
            err   = (ta == c_inf || ft < ta) ? 1 : 0;
        end else begin
            fired = (ta != c_inf && tb != c_inf && tb <= ta) ? 1 : 0;
            tq    = fired ? ta : c_inf;
            err   = 0;
        end
    endfunction

    task automatic wait_ready();
        int waited = 0;
        @(negedge aclk);
        while (!req_ready && waited < 64) begin
            @(negedge aclk);
            waited++;
        end
        check("req_ready_idle", 32'(req_ready), 32'd1);
    endtask

    task automatic do_txn(input int ta, input int tb, input int mode, input int ft, input int hold);
        int efired, etq, eerr, t;
        model(ta, tb, mode, ft, efired, etq, eerr);
        cell_mode = mode;
        fault_t   = ft;
        wait_ready();
        req_ta    = T_W'(ta);
        req_tb    = T_W'(tb);
        req_valid = 1'b1;
        @(negedge aclk);
        req_valid = 1'b0;
        for (int n = 1; n <= RST_CYCLES + GAMMA; n++) begin
            if (n > 1) @(negedge aclk);
            if (n <= RST_CYCLES) begin
                check("reset_cell_rst", 32'(cell_rst), 32'd1);
                check("reset_cell_a", 32'(cell_a), 32'd0);
                check("reset_cell_b", 32'(cell_b), 32'd0);
            end else begin
                t = n - RST_CYCLES - 1;
                check("run_cell_rst", 32'(cell_rst), 32'd0);
                check("run_step_a", 32'(cell_a), 32'((ta != c_inf && t >= ta) ? 1 : 0));
                check("run_step_b", 32'(cell_b), 32'((tb != c_inf && t >= tb) ? 1 : 0));
            end
            check("busy_active", 32'(busy), 32'd1);
            check("ready_blocked", 32'(req_ready), 32'd0);
            check("valid_early", 32'(rsp_valid), 32'd0);
        end
        for (int h = 0; h <= hold; h++) begin
            @(negedge aclk);
            check("rsp_valid", 32'(rsp_valid), 32'd1);
            check("rsp_fired", 32'(rsp_fired), 32'(efired));
            check("rsp_tq", 32'(rsp_tq), 32'(etq));
            check("rsp_err", 32'(rsp_err), 32'(eerr));
            check("done_cell_rst", 32'(cell_rst), 32'd1);
            check("done_cell_a", 32'(cell_a), 32'd0);
            check("done_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge aclk);
        rsp_ready = 1'b0;
        check("post_valid", 32'(rsp_valid), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        check("post_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int ta, tb, mode, ft, hold;

        grst = 1'b0;
        repeat (3) @(negedge aclk);
        check("rst_cell_rst", 32'(cell_rst), 32'd1);
        check("rst_cell_a", 32'(cell_a), 32'd0);
        check("rst_cell_b", 32'(cell_b), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_fired", 32'(rsp_fired), 32'd0);
        check("rst_tq", 32'(rsp_tq), 32'(c_inf));
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        grst = 1'b1;
        @(negedge aclk);
        check("rst_release_ready", 32'(req_ready), 32'd1);

        do_txn(5, 3, 0, 0, 0);
        do_txn(2, 7, 0, 0, 0);
        do_txn(4, 4, 0, 0, 0);
        do_txn(15, 0, 0, 0, 0);
        do_txn(5, 0, 1, 1, 0);
        do_txn(6, 2, 0, 0, 10);
        do_txn(0, 0, 0, 0, 0);
        do_txn(15, 15, 0, 0, 1);

        // Abort in the middle of RUN.
        cell_mode = 0;
        wait_ready();
        req_ta    = 4'd3;
        req_tb    = 4'd0;
        req_valid = 1'b1;
        @(negedge aclk);
        req_valid = 1'b0;
        repeat (RST_CYCLES + 6) @(negedge aclk);
        check("abort_pre_run", 32'(cell_rst), 32'd0);
        check("abort_pre_a", 32'(cell_a), 32'd1);
        #1 grst = 1'b0;
        #1;
        check("abort_cell_rst", 32'(cell_rst), 32'd1);
        check("abort_cell_a", 32'(cell_a), 32'd0);
        check("abort_cell_b", 32'(cell_b), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(rsp_valid), 32'd0);
        @(negedge aclk);
        grst = 1'b1;
        for (int i = 0; i < GAMMA + 4; i++) begin
            @(negedge aclk);
            check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        do_txn(1, 0, 0, 0, 0);

        for (int k = 0; k < 24; k++) begin
            ta   = $urandom_range(0, c_inf);
            tb   = $urandom_range(0, c_inf);
            mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
            ft   = $urandom_range(0, GAMMA - 1);
            hold = $urandom_range(0, 3);
            do_txn(ta, tb, mode, ft, hold);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
